// File: rtl/snn_pkg.sv
// Shared definitions for the SNN layer sequencer: flit layout, PE addressing,
// sequencer states and flit packing helpers.
package snn_pkg;

   typedef enum logic [1:0] {
      FLIT_IFMAP  = 2'b00,
      FLIT_FILTER = 2'b01,
      FLIT_OUTPUT = 2'b11
   } flit_type_e;

   typedef enum logic [3:0] {
      S_IDLE,
      S_FLT_REQ,
      S_FLT_WAIT,
      S_FLT_SEND,
      S_IF_REQ,
      S_IF_WAIT,
      S_IF_SEND,
      S_WAIT_DONE,
      S_FINISH
   } seq_state_e;

   localparam logic [3:0] PE_ROW0  = 4'b0001;
   localparam logic [3:0] PE_ROW1  = 4'b0101;
   localparam logic [3:0] PE_ROW2  = 4'b0011;
   localparam logic [3:0] PE_ROW3  = 4'b0111;
   localparam logic [3:0] PE_OTHER = 4'b1100;
   localparam logic [3:0] SRC_ID   = 4'b0000;

   localparam logic [9:0] DONE_CODE = 10'h3FF;
   localparam int TYPE_LSB = 54;
   localparam int ROW_LSB  = 5;

   function automatic logic [3:0] pe_dest(input logic [4:0] row);
      case (row)
         5'd0:    return PE_ROW0;
         5'd1:    return PE_ROW1;
         5'd2:    return PE_ROW2;
         5'd3:    return PE_ROW3;
         default: return PE_OTHER;
      endcase
   endfunction

   // Payload fields are zero-extended so narrower filter/ifmap rows keep the fixed layout.
   function automatic logic [63:0] pack_filter_flit(input logic [3:0] dest, input logic [47:0] row_bytes);
      return {dest, SRC_ID, FLIT_FILTER, 6'b0, row_bytes};
   endfunction

   function automatic logic [63:0] pack_ifmap_flit(input logic [3:0] dest, input logic [31:0] row_bits);
      return {dest, SRC_ID, FLIT_IFMAP, 22'b0, row_bits};
   endfunction

endpackage

// File: rtl/snn_wr_buffer.sv
// One-entry holding register between NoC output flits and the memory write port.
module snn_wr_buffer (
   input  logic       clk,
   input  logic       rst,
   input  logic       push_valid,
   output logic       push_ready,
   input  logic [3:0] push_t,
   input  logic [4:0] push_row,
   input  logic [4:0] push_col,
   output logic       pop_valid,
   input  logic       pop_ready,
   output logic [3:0] pop_t,
   output logic [4:0] pop_row,
   output logic [4:0] pop_col
);

   logic full;

   assign push_ready = !full;
   assign pop_valid  = full;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         full    <= 1'b0;
         pop_t   <= '0;
         pop_row <= '0;
         pop_col <= '0;
      end else if (push_valid && push_ready) begin
         full    <= 1'b1;
         pop_t   <= push_t;
         pop_row <= push_row;
         pop_col <= push_col;
      end else if (pop_valid && pop_ready) begin
         full <= 1'b0;
      end
   end

endmodule

// File: rtl/snn_layer_sequencer.sv
// Sequences one SNN conv layer: filter preload, per-timestep ifmap streaming to PEs,
// and ofmap write-back from NoC output flits through the shared memory port.
module snn_layer_sequencer
   import snn_pkg::*;
#(
   parameter int FILT_DIM   = 5,
   parameter int IFMAP_DIM  = 25,
   parameter int TIMESTEPS  = 2,
   parameter int DONE_COUNT = 7,
   parameter int NOC_W      = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             mem_req_valid,
   input  logic             mem_req_ready,
   output logic             mem_req_we,
   output logic [1:0]       mem_req_sel,
   output logic [3:0]       mem_req_t,
   output logic [4:0]       mem_req_row,
   output logic [4:0]       mem_req_col,
   input  logic             mem_rsp_valid,
   input  logic [7:0]       mem_rsp_data,
   output logic             noc_tx_valid,
   input  logic             noc_tx_ready,
   output logic [NOC_W-1:0] noc_tx_data,
   input  logic             noc_rx_valid,
   output logic             noc_rx_ready,
   input  logic [NOC_W-1:0] noc_rx_data,
   output logic [3:0]       timestep,
   output logic             busy,
   output logic             done
);

   localparam int          FW          = FILT_DIM * 8;
   localparam logic [4:0]  FILT_LAST   = 5'(FILT_DIM - 1);
   localparam logic [4:0]  IF_LAST     = 5'(IFMAP_DIM - 1);
   localparam logic [3:0]  T_LAST      = 4'(TIMESTEPS - 1);
   localparam logic [7:0]  DONE_TARGET = 8'(DONE_COUNT);

   seq_state_e           state;
   logic [4:0]           row;
   logic [4:0]           col;
   logic [3:0]           t;
   logic [7:0]           done_cnt;
   logic [FW-1:0]        filt_bits;
   logic [IFMAP_DIM-1:0] if_bits;

   logic       idle, rd_wait, wr_go, rd_go;
   logic       rx_fire, rx_output, rx_done, rx_unused;
   logic       buf_push_valid, buf_push_ready;
   logic       buf_valid;
   logic [3:0] buf_t;
   logic [4:0] buf_row, buf_col;

   assign idle    = (state == S_IDLE);
   assign rd_wait = (state == S_FLT_WAIT) || (state == S_IF_WAIT);

   // A pending write takes the port from an unissued read but never interrupts an outstanding one.
   assign wr_go = buf_valid && !idle && !rd_wait;
   assign rd_go = ((state == S_FLT_REQ) || (state == S_IF_REQ)) && !wr_go;

   assign rx_output      = (noc_rx_data[TYPE_LSB +: 2] == FLIT_OUTPUT);
   assign rx_done        = rx_output && (noc_rx_data[9:0] == DONE_CODE);
   assign noc_rx_ready   = buf_push_ready && !idle;
   assign rx_fire        = noc_rx_valid && noc_rx_ready;
   assign buf_push_valid = noc_rx_valid && !idle && rx_output && !rx_done;
   assign rx_unused      = ^{noc_rx_data[NOC_W-1:56], noc_rx_data[53:10]};

   snn_wr_buffer u_wr_buffer (
      .clk        (clk),
      .rst        (rst),
      .push_valid (buf_push_valid),
      .push_ready (buf_push_ready),
      .push_t     (t),
      .push_row   (noc_rx_data[ROW_LSB +: 5]),
      .push_col   (noc_rx_data[4:0]),
      .pop_valid  (buf_valid),
      .pop_ready  (mem_req_ready && wr_go),
      .pop_t      (buf_t),
      .pop_row    (buf_row),
      .pop_col    (buf_col)
   );

   always_comb begin
      mem_req_valid = 1'b0;
      mem_req_we    = 1'b0;
      mem_req_sel   = '0;
      mem_req_t     = '0;
      mem_req_row   = '0;
      mem_req_col   = '0;
      if (wr_go) begin
         mem_req_valid = 1'b1;
         mem_req_we    = 1'b1;
         mem_req_sel   = FLIT_OUTPUT;
         mem_req_t     = buf_t;
         mem_req_row   = buf_row;
         mem_req_col   = buf_col;
      end else if (rd_go) begin
         mem_req_valid = 1'b1;
         mem_req_sel   = (state == S_FLT_REQ) ? FLIT_FILTER : FLIT_IFMAP;
         mem_req_t     = (state == S_IF_REQ) ? t : 4'd0;
         mem_req_row   = row;
         mem_req_col   = col;
      end
   end

   always_comb begin
      noc_tx_valid = 1'b0;
      noc_tx_data  = '0;
      if (state == S_FLT_SEND) begin
         noc_tx_valid = 1'b1;
         noc_tx_data  = pack_filter_flit(pe_dest(row), 48'(filt_bits));
      end else if (state == S_IF_SEND) begin
         noc_tx_valid = 1'b1;
         noc_tx_data  = pack_ifmap_flit(pe_dest(row), 32'(if_bits));
      end
   end

   assign timestep = t;
   assign busy     = !idle && (state != S_FINISH);
   assign done     = (state == S_FINISH);

   // Row data is shifted in from the top so column 0 ends up in the lowest lane.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         row       <= '0;
         col       <= '0;
         t         <= '0;
         done_cnt  <= '0;
         filt_bits <= '0;
         if_bits   <= '0;
      end else begin
         if (rx_fire && rx_done && (state != S_FINISH) && (done_cnt != DONE_TARGET))
            done_cnt <= done_cnt + 8'd1;
         case (state)
            S_IDLE, S_FINISH: begin
               if (start) begin
                  state    <= S_FLT_REQ;
                  row      <= '0;
                  col      <= '0;
                  t        <= '0;
                  done_cnt <= '0;
               end
            end
            S_FLT_REQ: if (rd_go && mem_req_ready) state <= S_FLT_WAIT;
            S_FLT_WAIT: begin
               if (mem_rsp_valid) begin
                  filt_bits <= {mem_rsp_data, filt_bits[FW-1:8]};
                  if (col == FILT_LAST) begin
                     col   <= '0;
                     state <= S_FLT_SEND;
                  end else begin
                     col   <= col + 5'd1;
                     state <= S_FLT_REQ;
                  end
               end
            end
            S_FLT_SEND: begin
               if (noc_tx_ready) begin
                  if (row == FILT_LAST) begin
                     row   <= '0;
                     state <= S_IF_REQ;
                  end else begin
                     row   <= row + 5'd1;
                     state <= S_FLT_REQ;
                  end
               end
            end
            S_IF_REQ: if (rd_go && mem_req_ready) state <= S_IF_WAIT;
            S_IF_WAIT: begin
               if (mem_rsp_valid) begin
                  if_bits <= {mem_rsp_data[0], if_bits[IFMAP_DIM-1:1]};
                  if (col == IF_LAST) begin
                     col   <= '0;
                     state <= S_IF_SEND;
                  end else begin
                     col   <= col + 5'd1;
                     state <= S_IF_REQ;
                  end
               end
            end
            S_IF_SEND: begin
               if (noc_tx_ready) begin
                  if (row == IF_LAST) begin
                     row   <= '0;
                     state <= S_WAIT_DONE;
                  end else begin
                     row   <= row + 5'd1;
                     state <= S_IF_REQ;
                  end
               end
            end
            S_WAIT_DONE: begin
               if ((done_cnt == DONE_TARGET) && !buf_valid) begin
                  done_cnt <= '0;
                  if (t == T_LAST) begin
                     state <= S_FINISH;
                  end else begin
                     t     <= t + 4'd1;
                     state <= S_IF_REQ;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_snn_layer_sequencer.sv
// Scoreboard bench: expected flits and memory writes are queued by the stimulus,
// a memory model answers reads, and monitors pop and compare on every handshake.
module tb_snn_layer_sequencer;

   logic        clk, rst, start;
   logic        mem_req_valid, mem_req_ready, mem_req_we;
   logic [1:0]  mem_req_sel;
   logic [3:0]  mem_req_t;
   logic [4:0]  mem_req_row, mem_req_col;
   logic        mem_rsp_valid;
   logic [7:0]  mem_rsp_data;
   logic        noc_tx_valid, noc_tx_ready;
   logic [63:0] noc_tx_data;
   logic        noc_rx_valid, noc_rx_ready;
   logic [63:0] noc_rx_data;
   logic [3:0]  timestep;
   logic        busy, done;

   snn_layer_sequencer #(
      .FILT_DIM   (5),
      .IFMAP_DIM  (25),
      .TIMESTEPS  (2),
      .DONE_COUNT (7),
      .NOC_W      (64)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .mem_req_valid (mem_req_valid),
      .mem_req_ready (mem_req_ready),
      .mem_req_we    (mem_req_we),
      .mem_req_sel   (mem_req_sel),
      .mem_req_t     (mem_req_t),
      .mem_req_row   (mem_req_row),
      .mem_req_col   (mem_req_col),
      .mem_rsp_valid (mem_rsp_valid),
      .mem_rsp_data  (mem_rsp_data),
      .noc_tx_valid  (noc_tx_valid),
      .noc_tx_ready  (noc_tx_ready),
      .noc_tx_data   (noc_tx_data),
      .noc_rx_valid  (noc_rx_valid),
      .noc_rx_ready  (noc_rx_ready),
      .noc_rx_data   (noc_rx_data),
      .timestep      (timestep),
      .busy          (busy),
      .done          (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [63:0] flit;
      logic [3:0]  t;
   } tx_exp_t;

   tx_exp_t     tx_q[$];
   logic [13:0] wr_q[$];
   int          checks = 0;
   int          passes = 0;
   int          tx_seen = 0;
   int          pend_cnt = 0;
   int          mem_lat = 1;
   logic [7:0]  pend_data;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic fail(input string name);
      checks++;
      $display("FAIL %s: event did not occur as required", name);
   endtask

   function automatic logic [3:0] dest_of(input int r);
      case (r)
         0:       return 4'h1;
         1:       return 4'h5;
         2:       return 4'h3;
         3:       return 4'h7;
         default: return 4'hC;
      endcase
   endfunction

   // t0 ifmap is all ones; t1 ifmap has a single set bit on the diagonal
   function automatic logic [63:0] ifmap_flit(input int r, input int ts);
      logic [24:0] p;
      p = (ts == 0) ? 25'h1FF_FFFF : (25'd1 << r);
      return {dest_of(r), 4'h0, 2'b00, 29'b0, p};
   endfunction

   function automatic logic [63:0] out_flit(input logic [4:0] r, input logic [4:0] c);
      return {4'h0, 4'h0, 2'b11, 44'b0, r, c};
   endfunction

   function automatic logic [7:0] mem_val(input logic [1:0] sel, input logic [3:0] ts,
                                          input logic [4:0] r, input logic [4:0] c);
      if (sel == 2'b01) return 8'(int'(c) + 5 * int'(r));
      if (ts == 4'd0) return 8'h81;
      return (r == c) ? 8'h01 : 8'hFE;
   endfunction

   task automatic push_filter();
      logic [63:0] f [5];
      f = '{64'h1040_0004_0302_0100, 64'h5040_0009_0807_0605, 64'h3040_000E_0D0C_0B0A,
            64'h7040_0013_1211_100F, 64'hC040_0018_1716_1514};
      for (int i = 0; i < 5; i++) tx_q.push_back('{flit: f[i], t: 4'd0});
   endtask

   task automatic push_ifmap(input int ts);
      for (int r = 0; r < 25; r++) tx_q.push_back('{flit: ifmap_flit(r, ts), t: 4'(ts)});
   endtask

   // Memory model plus write-port monitor
   initial begin
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = 8'h00;
      forever begin
         @(negedge clk);
         mem_rsp_valid = 1'b0;
         if (mem_req_valid && mem_req_ready && mem_req_we) begin
            check("wr_no_preempt", 64'(pend_cnt), 64'd0);
            if (wr_q.size() == 0) fail("wr_unexpected");
            else check("wr_addr", {mem_req_sel, mem_req_t, mem_req_row, mem_req_col}, {2'b11, wr_q.pop_front()});
         end
         if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
               mem_rsp_valid = 1'b1;
               mem_rsp_data  = pend_data;
            end
         end
         if (mem_req_valid && mem_req_ready && !mem_req_we) begin
            pend_cnt  = mem_lat;
            pend_data = mem_val(mem_req_sel, mem_req_t, mem_req_row, mem_req_col);
         end
      end
   end

   // NoC transmit monitor
   initial begin
      logic        stalled;
      logic [63:0] held;
      tx_exp_t     e;
      stalled = 1'b0;
      held    = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            stalled = 1'b0;
         end else begin
            if (noc_tx_valid && !noc_tx_ready) begin
               if (stalled) check("tx_hold", noc_tx_data, held);
               held    = noc_tx_data;
               stalled = 1'b1;
            end else begin
               stalled = 1'b0;
            end
            if (noc_tx_valid && noc_tx_ready) begin
               if (tx_q.size() == 0) begin
                  fail("tx_unexpected");
               end else begin
                  e = tx_q.pop_front();
                  check("tx_flit", noc_tx_data, e.flit);
                  check("tx_t", 64'(timestep), 64'(e.t));
               end
               tx_seen++;
            end
         end
      end
   end

   task automatic wait_tx(input int n);
      for (int i = 0; i < 20000; i++) begin
         if (tx_seen >= n) begin
            @(posedge clk); #1;
            return;
         end
         @(negedge clk);
      end
      fail("tx_timeout");
      @(posedge clk); #1;
   endtask

   task automatic send_rx(input logic [63:0] f);
      noc_rx_valid = 1'b1;
      noc_rx_data  = f;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (noc_rx_ready) begin
            @(posedge clk); #1;
            noc_rx_valid = 1'b0;
            return;
         end
      end
      fail("rx_timeout");
      noc_rx_valid = 1'b0;
   endtask

   task automatic pulse_start();
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic check_reset_outs(input string name);
      check(name, 64'({mem_req_valid, mem_req_we, mem_req_sel, mem_req_t, mem_req_row, mem_req_col,
                       noc_tx_valid, noc_rx_ready, timestep, busy, done}), 64'd0);
      check({name, "_txdata"}, noc_tx_data, 64'd0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; mem_req_ready = 1'b1; noc_tx_ready = 1'b1;
      noc_rx_valid = 1'b0; noc_rx_data = '0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outs("reset_outs");
      rst = 1'b0;

      // Run 1: full layer, two timesteps
      push_filter();
      push_ifmap(0);
      push_ifmap(1);
      pulse_start();
      @(negedge clk);
      check("busy_after_start", 64'({busy, done}), 64'b10);
      wait_tx(5);
      mem_lat = 3;

      wait_tx(8);
      wr_q.push_back({4'd0, 5'd3, 5'd17});
      send_rx(out_flit(5'd3, 5'd17));
      noc_rx_valid = 1'b1;
      noc_rx_data  = out_flit(5'd20, 5'd0);
      @(negedge clk);
      check("rx_stall_buf_full", 64'(noc_rx_ready), 64'd0);
      wr_q.push_back({4'd0, 5'd20, 5'd0});
      send_rx(out_flit(5'd20, 5'd0));
      send_rx({4'h1, 4'h0, 2'b01, 44'b0, 10'h071});

      wait_tx(12);
      noc_tx_ready = 1'b0;
      begin : wait_valid
         for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (noc_tx_valid) disable wait_valid;
         end
         fail("tx_valid_timeout");
      end
      repeat (20) @(posedge clk);
      #1;
      noc_tx_ready = 1'b1;

      wait_tx(15);
      for (int i = 0; i < 9; i++) send_rx(out_flit(5'd31, 5'd31));

      wait_tx(55);
      repeat (40) @(posedge clk);
      @(negedge clk);
      check("hold_wait_done", 64'({mem_req_valid, busy, done, timestep}), 64'b0_10_0001);

      for (int i = 0; i < 7; i++) send_rx(out_flit(5'd31, 5'd31));
      begin : wait_fin
         for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done) disable wait_fin;
         end
      end
      check("finish_state", 64'({busy, done, timestep}), 64'b01_0001);

      wr_q.push_back({4'd1, 5'd31, 5'd30});
      @(posedge clk); #1;
      send_rx(out_flit(5'd31, 5'd30));
      send_rx(out_flit(5'd31, 5'd31));
      repeat (10) @(posedge clk);
      #1;
      check("wr_q_drained", 64'(wr_q.size()), 64'd0);

      // Run 2: restart from FINISH, abort with reset during the first t1 read
      push_filter();
      push_ifmap(0);
      pulse_start();
      @(negedge clk);
      check("restart_busy", 64'({busy, done, timestep}), 64'b10_0000);
      wait_tx(63);
      pulse_start();
      wait_tx(65);
      for (int i = 0; i < 7; i++) send_rx(out_flit(5'd31, 5'd31));
      wait_tx(85);
      begin : wait_t1_read
         for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (mem_req_valid && !mem_req_we && timestep == 4'd1) disable wait_t1_read;
         end
         fail("t1_read_timeout");
      end
      @(posedge clk); #1;
      check("pre_rst", 64'({busy, timestep}), 64'b1_0001);
      rst = 1'b1;
      #1;
      check_reset_outs("abort_outs");
      check("tx_q_after_abort", 64'(tx_q.size()), 64'd0);
      repeat (6) @(posedge clk);
      #1;
      rst = 1'b0;

      // Run 3: filter load must start from scratch
      push_filter();
      pulse_start();
      wait_tx(90);
      repeat (5) @(posedge clk);
      check("final_tx_q", 64'(tx_q.size()), 64'd0);
      check("final_wr_q", 64'(wr_q.size()), 64'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
